// File: rtl/note_entry.sv
// Pushbutton/switch front end for the note-sequence FSM: synchronizes raw inputs,
// debounces the button, and turns each press into an ok (valid note) or err pulse.
module note_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_NOTES       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ok_n,
  input  logic       tom_sw,
  input  logic [2:0] nota_sw,
  input  logic       fim,
  output logic       ok,
  output logic [2:0] nota,
  output logic       tom,
  output logic       err,
  output logic [2:0] count,
  output logic       full
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    MAX_C    = 3'(MAX_NOTES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic          ok_meta_q, ok_s_q;
  logic          tom_meta_q, tom_s_q;
  logic [2:0]    nota_meta_q, nota_s_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic [2:0]    eff_count;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [2:0]    nota_q, nota_d;
  logic          tom_q, tom_d;
  logic [2:0]    count_q, count_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ok_s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (ok_s_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (ok_s_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!ok_s_q) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A fim in the accept cycle starts the new sequence with this very note.
  always_comb begin
    eff_count = fim ? 3'd0 : count_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    nota_d    = nota_q;
    tom_d     = tom_q;
    count_d   = eff_count;
    if (accept) begin
      if (nota_s_q == 3'd7) begin
        err_d   = 1'b1;
        count_d = count_q;
      end else if (eff_count == MAX_C) begin
        err_d   = 1'b1;
        count_d = count_q;
      end else begin
        ok_d    = 1'b1;
        nota_d  = nota_s_q;
        tom_d   = tom_s_q;
        count_d = eff_count + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ok_meta_q   <= 1'b1;
      ok_s_q      <= 1'b1;
      tom_meta_q  <= 1'b0;
      tom_s_q     <= 1'b0;
      nota_meta_q <= 3'd0;
      nota_s_q    <= 3'd0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      nota_q      <= 3'd0;
      tom_q       <= 1'b0;
      count_q     <= 3'd0;
    end else begin
      ok_meta_q   <= ok_n;
      ok_s_q      <= ok_meta_q;
      tom_meta_q  <= tom_sw;
      tom_s_q     <= tom_meta_q;
      nota_meta_q <= nota_sw;
      nota_s_q    <= nota_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      nota_q      <= nota_d;
      tom_q       <= tom_d;
      count_q     <= count_d;
    end
  end

  assign ok    = ok_q;
  assign err   = err_q;
  assign nota  = nota_q;
  assign tom   = tom_q;
  assign count = count_q;
  assign full  = (count_q == MAX_C);

endmodule

// File: tb/tb_note_entry.sv
// Directed bench for note_entry with DEBOUNCE_CYCLES=4, MAX_NOTES=4.
module tb_note_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ok_n = 1'b1;
  logic       tom_sw = 1'b0;
  logic [2:0] nota_sw = 3'd0;
  logic       fim = 1'b0;
  logic       ok, tom, err, full;
  logic [2:0] nota, count;

  int vectors = 0;
  int miscompares = 0;
  int ok_seen = 0;
  int err_seen = 0;
  int dbl = 0;
  logic prev_ok = 1'b0;
  logic prev_err = 1'b0;
  int ok_base, err_base;

  logic p_pre_ok, p_pre_err, p_ok, p_err, p_tom, p_full, p_post_ok, p_post_err;
  logic [2:0] p_nota, p_count;

  note_entry #(.DEBOUNCE_CYCLES(4), .MAX_NOTES(4)) dut (
    .clk(clk), .reset(reset), .ok_n(ok_n), .tom_sw(tom_sw), .nota_sw(nota_sw),
    .fim(fim), .ok(ok), .nota(nota), .tom(tom), .err(err), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ok) ok_seen++;
    if (err) err_seen++;
    if ((ok && prev_ok) || (err && prev_err)) dbl++;
    prev_ok  = ok;
    prev_err = err;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Press and hold; the pulse lands 7 ticks after ok_n goes low.
  task automatic press(input logic [2:0] n, input logic t, input logic fim_at);
    nota_sw = n;
    tom_sw  = t;
    ok_n    = 1'b0;
    ticks(6);
    p_pre_ok  = ok;
    p_pre_err = err;
    if (fim_at) fim = 1'b1;
    tick();
    fim     = 1'b0;
    p_ok    = ok;
    p_err   = err;
    p_nota  = nota;
    p_tom   = tom;
    p_count = count;
    p_full  = full;
    tick();
    p_post_ok  = ok;
    p_post_err = err;
    ticks(4);
    ok_n = 1'b1;
    ticks(10);
  endtask

  initial begin
    // reset state
    ticks(3);
    chk("rst_ok", ok, 0);
    chk("rst_err", err, 0);
    chk("rst_nota", nota, 0);
    chk("rst_tom", tom, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    reset = 1'b1;
    ticks(10);

    // clean press
    ok_base = ok_seen;
    press(3'd3, 1'b1, 1'b0);
    chk("clean_pre_ok", p_pre_ok, 0);
    chk("clean_ok", p_ok, 1);
    chk("clean_err", p_err, 0);
    chk("clean_nota", p_nota, 3);
    chk("clean_tom", p_tom, 1);
    chk("clean_count", p_count, 1);
    chk("clean_post_ok", p_post_ok, 0);
    chk("clean_npulses", ok_seen - ok_base, 1);

    // bouncy press, then bouncy release
    ok_base = ok_seen;
    nota_sw = 3'd5;
    tom_sw  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ok_n = 1'b0; ticks(2);
      ok_n = 1'b1; ticks(1);
    end
    ok_n = 1'b0;
    ticks(15);
    chk("bounce_npulses", ok_seen - ok_base, 1);
    chk("bounce_nota", nota, 5);
    chk("bounce_tom", tom, 0);
    chk("bounce_count", count, 2);
    ok_n = 1'b1; ticks(2);
    ok_n = 1'b0; ticks(2);
    ok_n = 1'b1; ticks(15);
    chk("release_npulses", ok_seen - ok_base, 1);

    // invalid code
    ok_base  = ok_seen;
    err_base = err_seen;
    press(3'd7, 1'b1, 1'b0);
    chk("inv_err", p_err, 1);
    chk("inv_ok", p_ok, 0);
    chk("inv_nota", p_nota, 5);
    chk("inv_count", p_count, 2);
    chk("inv_post_err", p_post_err, 0);
    chk("inv_nok", ok_seen - ok_base, 0);
    chk("inv_nerr", err_seen - err_base, 1);

    // fim alone clears the count
    fim = 1'b1; tick(); fim = 1'b0;
    chk("fim0_count", count, 0);
    chk("fim0_nota", nota, 5);

    // sequence limit
    for (int i = 0; i < 4; i++) begin
      press(3'(i), 1'(i % 2), 1'b0);
      chk("lim_ok", p_ok, 1);
      chk("lim_nota", p_nota, i);
      chk("lim_count", p_count, i + 1);
      chk("lim_full", p_full, (i == 3) ? 1 : 0);
    end
    press(3'd4, 1'b0, 1'b0);
    chk("lim5_err", p_err, 1);
    chk("lim5_ok", p_ok, 0);
    chk("lim5_nota", p_nota, 3);
    chk("lim5_count", p_count, 4);
    chk("lim5_full", p_full, 1);

    // fim coincident with accept while full
    press(3'd6, 1'b1, 1'b1);
    chk("fimacc_ok", p_ok, 1);
    chk("fimacc_err", p_err, 0);
    chk("fimacc_count", p_count, 1);
    chk("fimacc_nota", p_nota, 6);
    chk("fimacc_full", p_full, 0);
    for (int i = 0; i < 3; i++) press(3'(i), 1'b0, 1'b0);
    chk("refill_count", count, 4);
    chk("refill_full", full, 1);
    fim = 1'b1; tick(); fim = 1'b0;
    chk("fim1_count", count, 0);
    chk("fim1_full", full, 0);
    chk("fim1_nota", nota, 2);

    // async reset during PRESS_WAIT, button held through release
    press(3'd5, 1'b1, 1'b0);
    press(3'd4, 1'b1, 1'b0);
    chk("pre_rst_count", count, 2);
    nota_sw = 3'd2;
    tom_sw  = 1'b1;
    ok_n    = 1'b0;
    ticks(4);
    #2 reset = 1'b0;
    #1;
    chk("arst_ok", ok, 0);
    chk("arst_err", err, 0);
    chk("arst_nota", nota, 0);
    chk("arst_tom", tom, 0);
    chk("arst_count", count, 0);
    chk("arst_full", full, 0);
    ticks(3);
    reset = 1'b1;
    ok_base = ok_seen;
    ticks(6);
    chk("held_pre_ok", ok, 0);
    tick();
    chk("held_ok", ok, 1);
    chk("held_nota", nota, 2);
    chk("held_tom", tom, 1);
    chk("held_count", count, 1);
    ok_n = 1'b1;
    ticks(12);
    chk("held_npulses", ok_seen - ok_base, 1);
    chk("no_double_pulse", dbl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
